id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register for the 5-stage MIPS datapath. It sits between decode/register-read and execute. It latches decoded control, operand data, register addresses and an extended immediate. Over a plain latch it adds stall (hold), flush (bubble insertion), a valid bit, selectable sign/zero immediate extension, and saturating stall/bubble event counters for pipeline-hazard debugging.

---
 rtl/id_ex_pipe_reg.sv | 145 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush, immediate extension and hazard counters
//
// Purpose: registers everything the execute stage needs from decode/register-read.
//   flush > stall > load on every rising edge; flush inserts a NOP bubble (all zeros).
//   The raw immediate is sign- or zero-extended before it is registered.
//   stall_cnt / bubble_cnt are saturating debug counters for pipeline hazard analysis.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   stall, flush         hold / bubble-insert controls
//   cnt_clr              synchronous clear of both event counters
//   in_valid + decode    control (ALUOp, RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg),
//                        ext_zero, operands (RsData, RtData), imm, register addresses
//   *Out                 registered copies of the above; ValidOut marks a real instruction
//   stall_cnt            edges on which a stall held the stage
//   bubble_cnt           bubbles inserted by flush
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  cnt_clr,
    input  logic                  in_valid,
    input  logic [ALUOP_W-1:0]    ALUOp,
    input  logic                  RegWrite,
    input  logic                  RegDst,
    input  logic                  ALUSrc,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  MemtoReg,
    input  logic                  ext_zero,
    input  logic [DATA_W-1:0]     RsData,
    input  logic [DATA_W-1:0]     RtData,
    input  logic [IMM_W-1:0]      imm,
    input  logic [REG_ADDR_W-1:0] RsAddr,
    input  logic [REG_ADDR_W-1:0] RtAddr,
    input  logic [REG_ADDR_W-1:0] RdAddr,
    output logic                  ValidOut,
    output logic [ALUOP_W-1:0]    ALUOpOut,
    output logic                  RegWriteOut,
    output logic                  RegDstOut,
    output logic                  ALUSrcOut,
    output logic                  MemWriteOut,
    output logic                  MemReadOut,
    output logic                  MemtoRegOut,
    output logic [DATA_W-1:0]     RsDataOut,
    output logic [DATA_W-1:0]     RtDataOut,
    output logic [DATA_W-1:0]     ImmOut,
    output logic [REG_ADDR_W-1:0] RsAddrOut,
    output logic [REG_ADDR_W-1:0] RtAddrOut,
    output logic [REG_ADDR_W-1:0] RdAddrOut,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic [DATA_W-1:0] imm_ext;

    // Extension happens on the input side so ImmOut is a pure register output.
    generate
        if (IMM_W < DATA_W) begin : g_ext
            assign imm_ext = ext_zero ? {{(DATA_W-IMM_W){1'b0}}, imm}
                                      : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end else begin : g_noext
            assign imm_ext = imm;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidOut    <= 1'b0;
            ALUOpOut    <= '0;
            RegWriteOut <= 1'b0;
            RegDstOut   <= 1'b0;
            ALUSrcOut   <= 1'b0;
            MemWriteOut <= 1'b0;
            MemReadOut  <= 1'b0;
            MemtoRegOut <= 1'b0;
            RsDataOut   <= '0;
            RtDataOut   <= '0;
            ImmOut      <= '0;
            RsAddrOut   <= '0;
            RtAddrOut   <= '0;
            RdAddrOut   <= '0;
        end else if (flush) begin
            // Bubble: all-zero stage is a NOP with no write or memory side effects.
            ValidOut    <= 1'b0;
            ALUOpOut    <= '0;
            RegWriteOut <= 1'b0;
            RegDstOut   <= 1'b0;
            ALUSrcOut   <= 1'b0;
            MemWriteOut <= 1'b0;
            MemReadOut  <= 1'b0;
            MemtoRegOut <= 1'b0;
            RsDataOut   <= '0;
            RtDataOut   <= '0;
            ImmOut      <= '0;
            RsAddrOut   <= '0;
            RtAddrOut   <= '0;
            RdAddrOut   <= '0;
        end else if (!stall) begin
            // Control is captured even for invalid slots; consumers gate on ValidOut.
            ValidOut    <= in_valid;
            ALUOpOut    <= ALUOp;
            RegWriteOut <= RegWrite;
            RegDstOut   <= RegDst;
            ALUSrcOut   <= ALUSrc;
            MemWriteOut <= MemWrite;
            MemReadOut  <= MemRead;
            MemtoRegOut <= MemtoReg;
            RsDataOut   <= RsData;
            RtDataOut   <= RtData;
            ImmOut      <= imm_ext;
            RsAddrOut   <= RsAddr;
            RtAddrOut   <= RtAddr;
            RdAddrOut   <= RdAddr;
        end
    end

    // Counters follow their own rules: a flush counts as a bubble even when
    // stall is also high, and such an edge is not counted as a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            if (bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else if (stall) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard-driven directed bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, cnt_clr, in_valid;
    logic [1:0]  ALUOp;
    logic        RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg, ext_zero;
    logic [31:0] RsData, RtData;
    logic [15:0] imm;
    logic [4:0]  RsAddr, RtAddr, RdAddr;

    logic        ValidOut, RegWriteOut, RegDstOut, ALUSrcOut, MemWriteOut, MemReadOut, MemtoRegOut;
    logic [1:0]  ALUOpOut;
    logic [31:0] RsDataOut, RtDataOut, ImmOut;
    logic [4:0]  RsAddrOut, RtAddrOut, RdAddrOut;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        v2, rw2, rd2, as2, mw2, mr2, m2r2;
    logic [1:0]  al2;
    logic [31:0] rs2, rt2, im2;
    logic [4:0]  rsa2, rta2, rda2;
    logic [1:0]  stall_cnt2, bubble_cnt2;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .ALUOp(ALUOp), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .ext_zero(ext_zero), .RsData(RsData), .RtData(RtData), .imm(imm),
        .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr),
        .ValidOut(ValidOut), .ALUOpOut(ALUOpOut), .RegWriteOut(RegWriteOut),
        .RegDstOut(RegDstOut), .ALUSrcOut(ALUSrcOut), .MemWriteOut(MemWriteOut),
        .MemReadOut(MemReadOut), .MemtoRegOut(MemtoRegOut), .RsDataOut(RsDataOut),
        .RtDataOut(RtDataOut), .ImmOut(ImmOut), .RsAddrOut(RsAddrOut),
        .RtAddrOut(RtAddrOut), .RdAddrOut(RdAddrOut),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance for saturation behaviour.
    id_ex_pipe_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .ALUOp(ALUOp), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .ext_zero(ext_zero), .RsData(RsData), .RtData(RtData), .imm(imm),
        .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr),
        .ValidOut(v2), .ALUOpOut(al2), .RegWriteOut(rw2), .RegDstOut(rd2),
        .ALUSrcOut(as2), .MemWriteOut(mw2), .MemReadOut(mr2), .MemtoRegOut(m2r2),
        .RsDataOut(rs2), .RtDataOut(rt2), .ImmOut(im2), .RsAddrOut(rsa2),
        .RtAddrOut(rta2), .RdAddrOut(rda2),
        .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
    );

    typedef struct packed {
        logic        valid;
        logic [1:0]  aluop;
        logic        rw, rdst, asrc, mw, mr, m2r;
        logic [31:0] rs, rt, imm;
        logic [4:0]  rsa, rta, rda;
        logic [15:0] scnt, bcnt;
        logic [1:0]  scnt2, bcnt2;
    } exp_t;

    exp_t st;
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic exp_t model_next(input exp_t cur);
        exp_t n;
        n = cur;
        if (flush) begin
            n.valid = 0; n.aluop = 0; n.rw = 0; n.rdst = 0; n.asrc = 0; n.mw = 0; n.mr = 0; n.m2r = 0;
            n.rs = 0; n.rt = 0; n.imm = 0; n.rsa = 0; n.rta = 0; n.rda = 0;
        end else if (!stall) begin
            n.valid = in_valid; n.aluop = ALUOp; n.rw = RegWrite; n.rdst = RegDst;
            n.asrc = ALUSrc; n.mw = MemWrite; n.mr = MemRead; n.m2r = MemtoReg;
            n.rs = RsData; n.rt = RtData;
            n.imm = ext_zero ? {16'h0000, imm} : {{16{imm[15]}}, imm};
            n.rsa = RsAddr; n.rta = RtAddr; n.rda = RdAddr;
        end
        if (cnt_clr) begin
            n.scnt = 0; n.bcnt = 0; n.scnt2 = 0; n.bcnt2 = 0;
        end else if (flush) begin
            if (n.bcnt != 16'hFFFF) n.bcnt = n.bcnt + 16'd1;
            if (n.bcnt2 != 2'b11)   n.bcnt2 = n.bcnt2 + 2'd1;
        end else if (stall) begin
            if (n.scnt != 16'hFFFF) n.scnt = n.scnt + 16'd1;
            if (n.scnt2 != 2'b11)   n.scnt2 = n.scnt2 + 2'd1;
        end
        return n;
    endfunction

    task automatic check_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(ValidOut), 32'(e.valid));
        chk({tag, "_aluop"}, 32'(ALUOpOut), 32'(e.aluop));
        chk({tag, "_ctrl"}, 32'({RegWriteOut, RegDstOut, ALUSrcOut, MemWriteOut, MemReadOut, MemtoRegOut}),
            32'({e.rw, e.rdst, e.asrc, e.mw, e.mr, e.m2r}));
        chk({tag, "_rs"}, RsDataOut, e.rs);
        chk({tag, "_rt"}, RtDataOut, e.rt);
        chk({tag, "_imm"}, ImmOut, e.imm);
        chk({tag, "_addr"}, 32'({RsAddrOut, RtAddrOut, RdAddrOut}), 32'({e.rsa, e.rta, e.rda}));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e.scnt));
        chk({tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'(e.bcnt));
        chk({tag, "_stall_cnt2"}, 32'(stall_cnt2), 32'(e.scnt2));
        chk({tag, "_bubble_cnt2"}, 32'(bubble_cnt2), 32'(e.bcnt2));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(ValidOut), 32'd0);
        chk({tag, "_aluop"}, 32'(ALUOpOut), 32'd0);
        chk({tag, "_ctrl"}, 32'({RegWriteOut, RegDstOut, ALUSrcOut, MemWriteOut, MemReadOut, MemtoRegOut}), 32'd0);
        chk({tag, "_rs"}, RsDataOut, 32'd0);
        chk({tag, "_rt"}, RtDataOut, 32'd0);
        chk({tag, "_imm"}, ImmOut, 32'd0);
        chk({tag, "_addr"}, 32'({RsAddrOut, RtAddrOut, RdAddrOut}), 32'd0);
        chk({tag, "_cnts"}, 32'({stall_cnt, bubble_cnt}), 32'd0);
        chk({tag, "_cnts2"}, 32'({stall_cnt2, bubble_cnt2}), 32'd0);
    endtask

    // Inputs are already driven; predict, advance one edge, then compare 1 ns later.
    task automatic do_step(input string tag);
        st = model_next(st);
        sb.push_back(st);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_ctrl(input logic v, input logic st_i, input logic fl, input logic clr);
        in_valid = v; stall = st_i; flush = fl; cnt_clr = clr;
    endtask

    task automatic randomize_inputs();
        ALUOp = 2'($urandom); RegWrite = 1'($urandom); RegDst = 1'($urandom);
        ALUSrc = 1'($urandom); MemWrite = 1'($urandom); MemRead = 1'($urandom);
        MemtoReg = 1'($urandom); ext_zero = 1'($urandom);
        RsData = $urandom; RtData = $urandom; imm = 16'($urandom);
        RsAddr = 5'($urandom); RtAddr = 5'($urandom); RdAddr = 5'($urandom);
    endtask

    initial begin
        st = '0;
        rst_n = 1'b0;
        set_ctrl(1, 0, 0, 0);
        randomize_inputs();
        RsData = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;
        randomize_inputs();
        set_ctrl(1, 0, 0, 0);
        RegWrite = 1; ALUOp = 2'b10; RsData = 32'h0000_0005; RtData = 32'h0000_0007; RdAddr = 5'd3;
        do_step("first_load");
        chk("first_load_rs_const", RsDataOut, 32'h0000_0005);

        imm = 16'h8001; ext_zero = 0;
        do_step("sext_neg");
        chk("sext_neg_const", ImmOut, 32'hFFFF_8001);
        ext_zero = 1;
        do_step("zext");
        chk("zext_const", ImmOut, 32'h0000_8001);
        imm = 16'h7FFF; ext_zero = 0;
        do_step("sext_pos");
        chk("sext_pos_const", ImmOut, 32'h0000_7FFF);

        RsData = 32'hDEAD_BEEF;
        do_step("stall_load");
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            set_ctrl(1, 1, 0, 0);
            do_step("stall_hold");
        end
        chk("stall_rs_const", RsDataOut, 32'hDEAD_BEEF);
        chk("stall_cnt_const", 32'(stall_cnt), 32'd3);
        chk("bubble_cnt_const", 32'(bubble_cnt), 32'd0);
        randomize_inputs();
        set_ctrl(1, 0, 0, 0);
        do_step("unstall");

        randomize_inputs();
        MemWrite = 1;
        set_ctrl(1, 1, 1, 0);
        do_step("flush_prio");

        set_ctrl(1, 0, 0, 1);
        do_step("cnt_clr");
        for (int i = 0; i < 5; i++) begin
            set_ctrl(1, 0, 1, 0);
            do_step("sat_flush");
        end
        chk("sat_bubble2_const", 32'(bubble_cnt2), 32'd3);
        set_ctrl(1, 0, 1, 1);
        do_step("clr_over_flush");

        for (int i = 0; i < 30; i++) begin
            randomize_inputs();
            set_ctrl(1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 9) == 0);
            do_step("random");
        end

        randomize_inputs();
        RsData = 32'hA5A5_0001;
        set_ctrl(1, 0, 0, 0);
        do_step("pre_async");
        set_ctrl(1, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        st = '0;
        #2 rst_n = 1'b1;
        randomize_inputs();
        set_ctrl(1, 0, 0, 0);
        do_step("post_reset_load");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
